hex_keypad_scan: RTL and testbench
==================================

// Module: hex_keypad_scan
//
// PURPOSE
//   Scans a 4x4 hex keypad matrix, debounces it and delivers one event per key press.
//   It drives the column lines one-hot active-low and samples the row lines.
//   It is the input-side counterpart of the multiplexed 8-digit hex display: each accepted digit
//   is shifted into a 32-bit word that the display can show directly, msb digit first.
//
// PARAMETERS
//   DWELL_BITS      13  column dwell = 2**DWELL_BITS clk cycles; legal range 3..20
//   DEBOUNCE_SCANS  4   consecutive identical full scans needed to accept a press or a release; legal range 1..15
//
// PORTS
//   clk        in   1   system clock; every register is on the posedge
//   reset      in   1   asynchronous, active-high reset
//   row        in   4   keypad rows, active-low, externally pulled up; asynchronous to clk
//   col        out  4   keypad column drive, one-hot active-low
//   clear      in   1   synchronous clear of data
//   key_valid  out  1   one-cycle pulse per accepted key press
//   key_code   out  4   hex value of the last accepted key; held until the next accept
//   key_down   out  1   high from accept until release is accepted
//   data       out  32  accepted digits, newest in [3:0], oldest in [31:28]
//
// BEHAVIOUR
//   Reset values
//   - col=4'b1110, key_valid=0, key_code=0, key_down=0, data=0.
//   - State is IDLE; all counters and the column index are 0.
//
//   Scanning
//   - row passes through a 2-flop synchronizer.
//   - The column index c counts 0,1,2,3 and wraps; col = ~(1<<c).
//   - Each column is driven for 2**DWELL_BITS cycles.
//   - Synchronized row is sampled on the last cycle of each dwell. Key (r,c) is pressed when row[r]==0 in that sample.
//   - One full scan is 4 dwells. At the end of a scan the result is one of:
//     NONE (no key), SINGLE(code) (exactly one key), MULTI (two or more keys).
//
//   Key map (row r, col c)
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: 0 F E D
//
//   FSM (evaluated once per scan end; cnt saturates at DEBOUNCE_SCANS)
//   - IDLE
//     - SINGLE(k): cand=k, cnt=1. Accept now if DEBOUNCE_SCANS==1, else go to DEBOUNCE.
//     - NONE or MULTI: stay in IDLE.
//   - DEBOUNCE
//     - SINGLE(cand): cnt+1; accept when cnt reaches DEBOUNCE_SCANS.
//     - SINGLE(other): cand=other, cnt=1.
//     - NONE or MULTI: go to IDLE.
//   - HELD
//     - NONE: cnt=1. Go to IDLE if DEBOUNCE_SCANS==1, else go to RELEASE.
//     - SINGLE or MULTI: stay in HELD. There is no auto-repeat.
//   - RELEASE
//     - NONE: cnt+1; go to IDLE when cnt reaches DEBOUNCE_SCANS.
//     - Any key: go back to HELD.
//   - Accept: go to HELD. In the cycle after the scan end:
//     - key_valid=1 for exactly 1 cycle;
//     - key_code=cand;
//     - data <= {data[27:0], cand}.
//   - key_down = (state==HELD || state==RELEASE).
//
//   Latency and boundaries
//   - Latency from a clean, stable press to key_valid: at most (DEBOUNCE_SCANS+1) scans + 3 cycles.
//   - A 9th digit shifts the oldest digit out of [31:28].
//   - clear in the same cycle as an accept: data = {28'h0, cand}. clear alone: data = 0.
//   - Reset mid-operation aborts immediately with no key_valid. Scanning restarts at c=0.
//
// TESTING (DWELL_BITS=3, DEBOUNCE_SCANS=3; scan = 32 cycles; keypad model shorts row to col)
//   1. Release reset, no keys -> col cycles 1110,1101,1011,0111, 8 cycles each.
//      key_valid never asserts; data=0.
//   2. Hold key 5 (r1,c1) for 300 cycles, then release -> exactly one key_valid.
//      key_code=4'h5, data=32'h00000005; key_down falls 3 empty scans after release.
//   3. Press and release 1,2,3,A,4,5,6,B,7 in turn -> 9 pulses; final data=32'h23A456B7.
//   4. Key 7 present for one scan, absent for one scan, present for one scan -> no key_valid.
//   5. Hold keys 1 and 2 together for 5 scans -> no key_valid.
//      Then release 2 -> one key_valid with key_code=4'h1.
//   6. Assert reset two scans into key 9 debounce -> no pulse.
//      After reset: key 9 held -> data=32'h9. Then clear coinciding with a key-0 accept -> data=32'h0, key_code=0.

Source files
------------

// File: rtl/hex_keypad_scan.sv
// hex_keypad_scan: scans a 4x4 active-low key matrix, debounces whole scans, emits one event per press.
// Latency: key_valid pulses the cycle after the scan end that completes DEBOUNCE_SCANS identical single-key scans.
// Backpressure: none; key_valid is a one-cycle pulse, key_code/data hold their value until the next accept.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   row[3:0]        keypad rows, active-low, asynchronous to clk (synchronized here)
//   col[3:0]        column drive, one-hot active-low
//   clear           synchronous clear of data
//   key_valid       one-cycle pulse per accepted key press
//   key_code[3:0]   hex value of the last accepted key
//   key_down        high from accept until the release has been accepted
//   data[31:0]      accepted digits, newest in [3:0], oldest in [31:28]
module hex_keypad_scan #(
    parameter int DWELL_BITS     = 13,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic [31:0] data
);
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t                state;
    logic [3:0]            row_s1, row_s2;
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic [1:0]            col_idx;
    logic [1:0]            acc_cnt;   // keys seen so far in this scan; 2 means two or more
    logic [3:0]            acc_code;  // code of the single key seen so far in this scan
    logic [3:0]            cand;
    logic [3:0]            cnt;

    logic       dwell_last, scan_end;
    logic [3:0] hits;
    logic [2:0] col_hits;
    logic [1:0] hit_row;
    logic [1:0] scan_cnt;
    logic [3:0] scan_key;
    logic       scan_none, scan_single;
    logic [3:0] cnt_inc;
    logic       accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        dwell_last = &dwell_cnt;
        scan_end   = dwell_last && (col_idx == 2'd3);
        hits       = ~row_s2;
        col_hits   = {2'b0, hits[0]} + {2'b0, hits[1]} + {2'b0, hits[2]} + {2'b0, hits[3]};
        hit_row    = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (hits[r]) hit_row = 2'(r);
        end
        // Running scan result including the column being sampled now
        if (({1'b0, acc_cnt} + col_hits) >= 3'd2) scan_cnt = 2'd2;
        else                                      scan_cnt = acc_cnt + col_hits[1:0];
        scan_key    = (acc_cnt == 2'd0) ? key_map(hit_row, col_idx) : acc_code;
        scan_none   = (scan_cnt == 2'd0);
        scan_single = (scan_cnt == 2'd1);
        cnt_inc     = (cnt >= DS) ? cnt : cnt + 4'd1;
        accept      = scan_end && scan_single &&
                      ((state == IDLE && DS == 4'd1) ||
                       (state == DEBOUNCE && scan_key == cand && cnt_inc == DS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            acc_cnt   <= 2'd0;
            acc_code  <= 4'h0;
            cand      <= 4'h0;
            cnt       <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_down  <= 1'b0;
            data      <= 32'h0;
        end else begin
            row_s1    <= row;
            row_s2    <= row_s1;
            dwell_cnt <= dwell_cnt + DWELL_BITS'(1);
            key_valid <= accept;

            if (dwell_last) begin
                col_idx <= col_idx + 2'd1;
                if (scan_end) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_cnt  <= scan_cnt;
                    acc_code <= scan_key;
                end
            end

            if (accept) begin
                state    <= HELD;
                key_down <= 1'b1;
                key_code <= scan_key;
                cand     <= scan_key;
                cnt      <= DS;
            end else if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_single) begin
                            cand  <= scan_key;
                            cnt   <= 4'd1;
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_single) begin
                            if (scan_key == cand) begin
                                cnt <= cnt_inc;
                            end else begin
                                cand <= scan_key;
                                cnt  <= 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                    HELD: begin
                        // No auto-repeat: a held key (or several) just keeps us here
                        if (scan_none) begin
                            cnt <= 4'd1;
                            if (DS == 4'd1) begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (scan_none) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DS) begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // An accept coinciding with clear leaves only the new digit
            if (accept)     data <= clear ? {28'h0, scan_key} : {data[27:0], scan_key};
            else if (clear) data <= 32'h0;
        end
    end
endmodule

// File: tb/tb_hex_keypad_scan.sv
`timescale 1ns/1ps
module tb_hex_keypad_scan;
    localparam int DW    = 3;
    localparam int DS    = 3;
    localparam int DWELL = 1 << DW;
    localparam int SCAN  = 4 * DWELL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_down;
    logic [31:0] data;
    logic [15:0] keys = 16'h0;   // bit r*4+c = switch at row r, column c closed

    hex_keypad_scan #(.DWELL_BITS(DW), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .clear(clear),
        .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .data(data)
    );

    always #5 clk = ~clk;

    // A closed switch shorts its row to its column driver
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    typedef struct {
        int          cyc;
        logic [3:0]  code;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-scan results judged by run lengths.
    // A digit is accepted when DS consecutive scans see the same single key while armed;
    // accepting disarms, and DS consecutive empty scans re-arm.
    logic [31:0] m_data;
    logic [3:0]  m_code;
    int          run_len, run_code, none_run;
    bit          armed;

    task automatic model_reset();
        m_data = 32'h0; m_code = 4'h0;
        run_len = 0; run_code = -1; none_run = 0; armed = 1'b1;
    endtask

    task automatic model_scan(input logic [15:0] k, input bit clr, output bit acc, output logic [3:0] code);
        int n;
        n = $countones(k);
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (k[i]) code = 4'(keymap[i]);
        if (n == 1) begin
            if (run_len > 0 && run_code == int'(code)) run_len++;
            else begin run_code = int'(code); run_len = 1; end
            none_run = 0;
        end else if (n == 0) begin
            run_len = 0;
            none_run++;
        end else begin
            run_len = 0;
            none_run = 0;
        end
        if (!armed && none_run >= DS) armed = 1'b1;
        acc = armed && (n == 1) && (run_len == DS);
        if (acc) begin
            armed  = 1'b0;
            m_code = code;
            m_data = clr ? {28'h0, code} : {m_data[27:0], code};
        end else if (clr) begin
            m_data = 32'h0;
        end
    endtask

    function automatic logic [15:0] km(input int code);
        logic [15:0] m;
        m = 16'h0;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) m = 16'(1) << i;
        return m;
    endfunction

    // One full scan, called at the negedge that begins it
    task automatic run_scan(input logic [15:0] k, input bit clr);
        bit         acc;
        logic [3:0] code;
        logic [3:0] ec;
        check("key_down", {31'h0, key_down}, {31'h0, !armed});
        check("data", data, m_data);
        check("key_code", {28'h0, key_code}, {28'h0, m_code});
        keys  = k;
        clear = clr;
        model_scan(k, clr, acc, code);
        if (acc) exp_q.push_back('{cyc + SCAN, code, m_data});
        for (int i = 0; i < SCAN; i++) begin
            ec = 4'b0001 << (i / DWELL);
            ec = ~ec;
            check("col", {28'h0, col}, {28'h0, ec});
            @(negedge clk);
        end
    endtask

    task automatic hold(input logic [15:0] k, input int n, input bit clr);
        for (int s = 0; s < n; s++) run_scan(k, clr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"}, {28'h0, col}, 32'h0000000E);
        check({tag, "_key_valid"}, {31'h0, key_valid}, 32'h0);
        check({tag, "_key_down"}, {31'h0, key_down}, 32'h0);
        check({tag, "_key_code"}, {28'h0, key_code}, 32'h0);
        check({tag, "_data"}, data, 32'h0);
    endtask

    task automatic reset_mid(input logic [15:0] k, input int ncyc);
        keys  = k;
        clear = 1'b0;
        repeat (ncyc) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        check("queue_empty_at_reset", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every key_valid pulse must match the oldest expected accept
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && key_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_key_valid: got pulse with key_code %h at cyc %0d, expected none", key_code, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_code", {28'h0, key_code}, {28'h0, e.code});
                check("pulse_data", data, e.data);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    int seq [9] = '{1, 2, 3, 10, 4, 5, 6, 11, 7};

    initial begin : stim
        logic [15:0] k;
        int          t;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // 1: idle scanning
        hold(16'h0, 3, 1'b0);

        // 2: key 5 held then released
        hold(km(5), 10, 1'b0);
        check("t2_data", data, 32'h00000005);
        check("t2_code", {28'h0, key_code}, 32'h5);
        hold(16'h0, 4, 1'b0);

        // 3: nine digits in turn
        for (int d = 0; d < 9; d++) begin
            hold(km(seq[d]), 4, 1'b0);
            hold(16'h0, 4, 1'b0);
        end
        check("t3_data", data, 32'h23A456B7);

        // 4: bouncing key 7
        run_scan(km(7), 1'b0);
        run_scan(16'h0, 1'b0);
        run_scan(km(7), 1'b0);
        hold(16'h0, 3, 1'b0);

        // 5: two keys, then one
        hold(km(1) | km(2), 5, 1'b0);
        hold(km(1), 4, 1'b0);
        check("t5_code", {28'h0, key_code}, 32'h1);
        hold(16'h0, 4, 1'b0);

        // 6: reset during debounce, then accept, then clear with accept
        hold(km(9), 2, 1'b0);
        reset_mid(km(9), 12);
        hold(km(9), 4, 1'b0);
        check("t6_data9", data, 32'h00000009);
        hold(16'h0, 4, 1'b0);
        hold(km(0), 2, 1'b0);
        run_scan(km(0), 1'b1);
        check("t6_data_clear", data, 32'h0);
        check("t6_code0", {28'h0, key_code}, 32'h0);
        hold(16'h0, 4, 1'b0);

        // Random key sets held for whole scans
        for (int s = 0; s < 60; s++) begin
            t = $urandom_range(0, 99);
            if (t < 35)      k = 16'h0;
            else if (t < 80) k = 16'(1) << $urandom_range(0, 15);
            else begin
                k = 16'($urandom);
                if ($countones(k) < 2) k = k | 16'h8001;
            end
            hold(k, $urandom_range(1, 5), ($urandom_range(0, 9) == 0));
        end
        hold(16'h0, DS + 2, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
